// File: rtl/pong_match_ctrl.sv
// Match-flow sequencer for pong: idle, serve countdown, rally, point pause, game over.
// Define PONG_WIN_BY_TWO_EN to require a two-point margin (or the higher score at 15) to win.
module pong_match_ctrl #(
   parameter int unsigned WIN_SCORE   = 10,
   parameter int unsigned SERVE_TICKS = 60,
   parameter int unsigned POINT_TICKS = 90,
   parameter int unsigned TICK_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       frame_tick,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       play_en,
   output logic       ball_reset,
   output logic       serve_pulse,
   output logic       serve_dir,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StOver  = 3'd4
   } state_e;

   localparam logic [3:0]        WinVal    = 4'(WIN_SCORE);
   localparam logic [TICK_W-1:0] ServeLast = TICK_W'(SERVE_TICKS - 1);
   localparam logic [TICK_W-1:0] PointLast = TICK_W'(POINT_TICKS - 1);

   state_e            state_q, state_d;
   logic [TICK_W-1:0] cnt_q, cnt_d;
   logic [3:0]        score1_q, score1_d, score2_q, score2_d;
   logic              serve_dir_q, serve_dir_d;
   logic              winner_q, winner_d;
   logic              start_q;
   logic              play_en_q, play_en_d;
   logic              ball_reset_q, ball_reset_d;
   logic              serve_pulse_q, serve_pulse_d;
   logic              game_over_q, game_over_d;
   logic              start_rise;
   logic              p1_win, p2_win;

   assign start_rise = start_btn & ~start_q;

`ifdef PONG_WIN_BY_TWO_EN
   logic [4:0] s1_x, s2_x;
   assign s1_x = {1'b0, score1_q};
   assign s2_x = {1'b0, score2_q};
   assign p1_win = ((score1_q >= WinVal) && (s1_x >= s2_x + 5'd2)) ||
                   ((score1_q == 4'hf) && (score1_q > score2_q));
   assign p2_win = ((score2_q >= WinVal) && (s2_x >= s1_x + 5'd2)) ||
                   ((score2_q == 4'hf) && (score2_q > score1_q));
`else
   assign p1_win = (score1_q == WinVal);
   assign p2_win = (score2_q == WinVal);
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      score1_d    = score1_q;
      score2_d    = score2_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      case (state_q)
         StIdle, StOver: begin
            if (start_rise) begin
               state_d     = StServe;
               score1_d    = '0;
               score2_d    = '0;
               serve_dir_d = 1'b1;
               winner_d    = 1'b0;
            end
         end
         StServe: begin
            if (frame_tick) begin
               if (cnt_q == ServeLast) state_d = StPlay;
               else                    cnt_d   = cnt_q + 1'b1;
            end
         end
         StPlay: begin
            // Simultaneous misses credit P2 only.
            if (miss_left) begin
               score2_d    = score2_q + {3'b000, (score2_q != 4'hf)};
               serve_dir_d = 1'b0;
               state_d     = StPoint;
            end else if (miss_right) begin
               score1_d    = score1_q + {3'b000, (score1_q != 4'hf)};
               serve_dir_d = 1'b1;
               state_d     = StPoint;
            end
         end
         StPoint: begin
            if (frame_tick) begin
               if (cnt_q == PointLast) begin
                  if (p1_win) begin
                     state_d  = StOver;
                     winner_d = 1'b0;
                  end else if (p2_win) begin
                     state_d  = StOver;
                     winner_d = 1'b1;
                  end else begin
                     state_d  = StServe;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) cnt_d = '0;

      // Outputs are registered from the next state so they line up with state_q.
      play_en_d     = (state_d == StPlay);
      ball_reset_d  = (state_d != StPlay);
      game_over_d   = (state_d == StOver);
      serve_pulse_d = (state_q == StServe) && (state_d == StPlay);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         score1_q      <= '0;
         score2_q      <= '0;
         serve_dir_q   <= 1'b1;
         winner_q      <= 1'b0;
         start_q       <= 1'b0;
         play_en_q     <= 1'b0;
         ball_reset_q  <= 1'b1;
         serve_pulse_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         score1_q      <= score1_d;
         score2_q      <= score2_d;
         serve_dir_q   <= serve_dir_d;
         winner_q      <= winner_d;
         start_q       <= start_btn;
         play_en_q     <= play_en_d;
         ball_reset_q  <= ball_reset_d;
         serve_pulse_q <= serve_pulse_d;
         game_over_q   <= game_over_d;
      end
   end

   assign play_en     = play_en_q;
   assign ball_reset  = ball_reset_q;
   assign serve_pulse = serve_pulse_q;
   assign serve_dir   = serve_dir_q;
   assign score1      = score1_q;
   assign score2      = score2_q;
   assign game_over   = game_over_q;
   assign winner      = winner_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl with WIN_SCORE=3, SERVE_TICKS=2, POINT_TICKS=3.
module tb_pong_match_ctrl;

   localparam int unsigned Win = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_btn = 1'b0;
   logic       frame_tick = 1'b0;
   logic       miss_left = 1'b0;
   logic       miss_right = 1'b0;
   logic       play_en, ball_reset, serve_pulse, serve_dir, game_over, winner;
   logic [3:0] score1, score2;
   logic [2:0] state;

   pong_match_ctrl #(
      .WIN_SCORE  (3),
      .SERVE_TICKS(2),
      .POINT_TICKS(3),
      .TICK_W     (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_btn  (start_btn),
      .frame_tick (frame_tick),
      .miss_left  (miss_left),
      .miss_right (miss_right),
      .play_en    (play_en),
      .ball_reset (ball_reset),
      .serve_pulse(serve_pulse),
      .serve_dir  (serve_dir),
      .score1     (score1),
      .score2     (score2),
      .game_over  (game_over),
      .winner     (winner),
      .state      (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       sd;
      logic       w;
      logic       sp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state
   logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0;
   logic       m_sd = 1'b1, m_w = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [2:0] st, input logic sp);
      exp_t e;
      e.tag = tag; e.st = st; e.s1 = m_s1; e.s2 = m_s2; e.sd = m_sd; e.w = m_w; e.sp = sp;
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         check_eq("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check_eq({e.tag, ".state"}, 32'(state), 32'(e.st));
      check_eq({e.tag, ".play_en"}, 32'(play_en), 32'(e.st == 3'd2));
      check_eq({e.tag, ".ball_reset"}, 32'(ball_reset), 32'(e.st != 3'd2));
      check_eq({e.tag, ".game_over"}, 32'(game_over), 32'(e.st == 3'd4));
      check_eq({e.tag, ".serve_pulse"}, 32'(serve_pulse), 32'(e.sp));
      check_eq({e.tag, ".serve_dir"}, 32'(serve_dir), 32'(e.sd));
      check_eq({e.tag, ".score1"}, 32'(score1), 32'(e.s1));
      check_eq({e.tag, ".score2"}, 32'(score2), 32'(e.s2));
      check_eq({e.tag, ".winner"}, 32'(winner), 32'(e.w));
   endtask

   task automatic step(input string tag, input logic [2:0] st, input logic sp);
      push_exp(tag, st, sp);
      cycle();
      pop_cmp();
   endtask

   function automatic logic wins(input logic [3:0] a, input logic [3:0] b);
`ifdef PONG_WIN_BY_TWO_EN
      return ((int'(a) >= Win) && (int'(a) >= int'(b) + 2)) || ((a == 4'hf) && (a > b));
`else
      return int'(a) == Win;
`endif
   endfunction

   task automatic serve_to_play(input string tag);
      frame_tick = 1'b1;
      step({tag, ".tick1"}, 3'd1, 1'b0);
      step({tag, ".tick2"}, 3'd2, 1'b1);
      frame_tick = 1'b0;
      step({tag, ".rally"}, 3'd2, 1'b0);
   endtask

   // left: P1 misses (P2 scores); both: drive both misses together.
   task automatic play_point(input string tag, input logic left, input logic both,
                             output logic over);
      logic [2:0] nxt;
      miss_left  = left | both;
      miss_right = ~left | both;
      if (left | both) begin
         if (m_s2 != 4'hf) m_s2 = m_s2 + 4'd1;
         m_sd = 1'b0;
      end else begin
         if (m_s1 != 4'hf) m_s1 = m_s1 + 4'd1;
         m_sd = 1'b1;
      end
      step({tag, ".miss"}, 3'd3, 1'b0);
      miss_left  = 1'b0;
      miss_right = 1'b0;
      frame_tick = 1'b1;
      step({tag, ".pause1"}, 3'd3, 1'b0);
      step({tag, ".pause2"}, 3'd3, 1'b0);
      nxt = 3'd1;
      if (wins(m_s1, m_s2)) begin
         nxt = 3'd4; m_w = 1'b0;
      end else if (wins(m_s2, m_s1)) begin
         nxt = 3'd4; m_w = 1'b1;
      end
      step({tag, ".pause3"}, nxt, 1'b0);
      frame_tick = 1'b0;
      over = (nxt == 3'd4);
   endtask

   task automatic new_match(input string tag);
      start_btn = 1'b1;
      m_s1 = 4'd0; m_s2 = 4'd0; m_sd = 1'b1; m_w = 1'b0;
      step(tag, 3'd1, 1'b0);
      start_btn = 1'b0;
   endtask

   initial begin
      logic over;
      step("reset", 3'd0, 1'b0);
      reset = 1'b0;
      step("idle", 3'd0, 1'b0);

      start_btn = 1'b1;
      step("start", 3'd1, 1'b0);
      for (int i = 0; i < 9; i++) step("start_hold", 3'd1, 1'b0);
      start_btn = 1'b0;
      serve_to_play("serve1");

      frame_tick = 1'b1;
      step("play_tick_ignored", 3'd2, 1'b0);
      frame_tick = 1'b0;

      play_point("p1_point", 1'b0, 1'b0, over);
      serve_to_play("serve2");
      play_point("double_miss", 1'b1, 1'b1, over);

      for (int i = 0; i < 2; i++) begin
         serve_to_play("serve_p2");
         play_point("p2_point", 1'b1, 1'b0, over);
      end
      check_eq("p2_reached_over", 32'(state), 32'd4);

      miss_left = 1'b1; miss_right = 1'b1; frame_tick = 1'b1;
      step("over_hold1", 3'd4, 1'b0);
      step("over_hold2", 3'd4, 1'b0);
      miss_left = 1'b0; miss_right = 1'b0; frame_tick = 1'b0;

      new_match("restart");
      for (int i = 0; i < 2; i++) begin
         serve_to_play("serve_r");
         play_point("r_point", 1'b0, 1'b0, over);
      end
      serve_to_play("serve_before_reset");
      reset = 1'b1;
      m_s1 = 4'd0; m_s2 = 4'd0; m_sd = 1'b1; m_w = 1'b0;
      step("mid_play_reset", 3'd0, 1'b0);
      reset = 1'b0;
      miss_left = 1'b1;
      step("idle_miss_ignored", 3'd0, 1'b0);
      miss_left = 1'b0;

      new_match("final_match");
`ifdef PONG_WIN_BY_TWO_EN
      for (int i = 0; i < 3; i++) begin
         serve_to_play("wb2_serve_a");
         play_point("wb2_p1", 1'b0, 1'b0, over);
         serve_to_play("wb2_serve_b");
         play_point("wb2_p2", 1'b1, 1'b0, over);
      end
      serve_to_play("wb2_serve_c");
      play_point("wb2_4_3", 1'b0, 1'b0, over);
      check_eq("wb2_4_3_not_over", 32'(state), 32'd1);
      serve_to_play("wb2_serve_d");
      play_point("wb2_5_3", 1'b0, 1'b0, over);
      check_eq("wb2_5_3_winner", 32'(winner), 32'd0);
`else
      for (int i = 0; i < 3; i++) begin
         serve_to_play("p1_run_serve");
         play_point("p1_run", 1'b0, 1'b0, over);
      end
      check_eq("p1_winner", 32'(winner), 32'd0);
`endif
      check_eq("final_over", 32'(game_over), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
